// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the register-file / ALU / RAM datapath.
// Takes one instruction per handshake and steps the datapath strobes state by state.
module datapath_sequencer #(
    parameter bit TRAP_ON_OF = 1'b1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        ZF,
    input  logic        OF,
    output logic        Write_Reg,
    output logic        Mem_Write,
    output logic [2:0]  ALU_OP,
    output logic [1:0]  wr_data_s,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        ovf_trap,
    output logic        zf_q
);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [1:0] {K_RTYPE, K_LOAD, K_STORE, K_ILLEGAL} kind_t;

    state_t      state;
    state_t      state_n;
    kind_t       kind;
    logic [31:0] ir;
    logic [2:0]  alu_dec;
    logic        addsub;
    logic        done_n;
    logic        illegal_n;
    logic        ovf_n;
    logic        unused_shamt;

    assign unused_shamt = ^ir[10:6];

    // Everything is decoded from IR, so ALU_OP and the instruction class stay frozen until the next accept.
    always_comb begin
        kind    = K_ILLEGAL;
        alu_dec = 3'b100;
        addsub  = 1'b0;
        case (ir[31:26])
            6'b000000: begin
                kind = K_RTYPE;
                case (ir[5:0])
                    6'b100000: begin alu_dec = 3'b100; addsub = 1'b1; end
                    6'b100010: begin alu_dec = 3'b101; addsub = 1'b1; end
                    6'b100100: alu_dec = 3'b000;
                    6'b100101: alu_dec = 3'b001;
                    6'b100110: alu_dec = 3'b010;
                    6'b100111: alu_dec = 3'b011;
                    6'b101011: alu_dec = 3'b110;
                    6'b000100: alu_dec = 3'b111;
                    default:   kind = K_ILLEGAL;
                endcase
            end
            6'b100011: kind = K_LOAD;
            6'b101011: kind = K_STORE;
            default:   kind = K_ILLEGAL;
        endcase
    end

    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        illegal_n = 1'b0;
        ovf_n     = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) state_n = DECODE;
            end
            DECODE: begin
                if (kind == K_ILLEGAL) begin
                    state_n   = IDLE;
                    done_n    = 1'b1;
                    illegal_n = 1'b1;
                end else begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (kind == K_RTYPE) begin
                    if (TRAP_ON_OF && addsub && OF) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        ovf_n   = 1'b1;
                    end else begin
                        state_n = WB;
                    end
                end else begin
                    state_n = MEM;
                end
            end
            MEM: begin
                if (kind == K_LOAD) begin
                    state_n = WB;
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            WB: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ir       <= 32'd0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            ovf_trap <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state    <= state_n;
            done     <= done_n;
            illegal  <= illegal_n;
            ovf_trap <= ovf_n;
            if (state == IDLE && instr_valid) ir <= instr;
            if (state == EXEC) zf_q <= ZF;
        end
    end

    // Strobes are gated by Reset so an abort can never leave a half-finished commit behind.
    assign Write_Reg   = (state == WB) && !Reset;
    assign Mem_Write   = (state == MEM) && (kind == K_STORE) && !Reset;
    assign wr_data_s   = {1'b0, ((state == MEM) || (state == WB)) && (kind == K_LOAD)};
    assign ALU_OP      = alu_dec;
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign instr_ready = (state == IDLE) && !Reset;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: two copies (trap on / trap off) drive a behavioural datapath,
// and a funct-level reference model predicts timing, strobes and register/RAM contents.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [1:0]  instrValid;
    logic [1:0]  instrReady, zfIn, ofIn, writeReg, memWrite, busy, done, illegal, ovfTrap, zfQ;
    logic [2:0]  aluOp [2];
    logic [1:0]  wrDataS [2];
    logic [4:0]  rsOut [2];
    logic [4:0]  rtOut [2];
    logic [4:0]  rdOut [2];

    logic [31:0] regs [2][32];
    logic [31:0] ram [2][64];
    logic [31:0] rdA [2];
    logic [31:0] rdB [2];
    logic [31:0] aluF [2];
    logic [31:0] wrData [2];

    logic        plEn;
    logic        plRam;
    logic [5:0]  plIdx;
    logic [31:0] plData;

    logic [31:0] expRegs [2][32];
    logic [31:0] expRam [2][64];
    logic        expZf [2];

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    // Instance 0 traps on overflow, instance 1 does not; both see the same instruction stream.
    for (genvar g = 0; g < 2; g++) begin : gDut
        datapath_sequencer #(.TRAP_ON_OF(g == 0 ? 1'b1 : 1'b0)) dut (
            .clk        (clk),
            .Reset      (reset),
            .instr      (instr),
            .instr_valid(instrValid[g]),
            .instr_ready(instrReady[g]),
            .ZF         (zfIn[g]),
            .OF         (ofIn[g]),
            .Write_Reg  (writeReg[g]),
            .Mem_Write  (memWrite[g]),
            .ALU_OP     (aluOp[g]),
            .wr_data_s  (wrDataS[g]),
            .rs         (rsOut[g]),
            .rt         (rtOut[g]),
            .rd         (rdOut[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .illegal    (illegal[g]),
            .ovf_trap   (ovfTrap[g]),
            .zf_q       (zfQ[g])
        );
    end

    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return a + b;
            3'b101:  return a - b;
            3'b110:  return (a < b) ? 32'd1 : 32'd0;
            default: return b << a[4:0];
        endcase
    endfunction

    function automatic logic ofModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        if (op == 3'b100) begin
            s = a + b;
            return (a[31] == b[31]) && (s[31] != a[31]);
        end
        if (op == 3'b101) begin
            s = a - b;
            return (a[31] != b[31]) && (s[31] != a[31]);
        end
        return 1'b0;
    endfunction

    // Behavioural datapath: combinational reads, ALU and flags.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdA[i]    = regs[i][rsOut[i]];
            rdB[i]    = regs[i][rtOut[i]];
            aluF[i]   = aluModel(aluOp[i], rdA[i], rdB[i]);
            zfIn[i]   = (aluF[i] == 32'd0);
            ofIn[i]   = ofModel(aluOp[i], rdA[i], rdB[i]);
            wrData[i] = (wrDataS[i] == 2'b01) ? ram[i][aluF[i][5:0]] : aluF[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (plEn) begin
                if (plRam) ram[i][plIdx] <= plData;
                else       regs[i][plIdx[4:0]] <= plData;
            end
            if (writeReg[i]) regs[i][rdOut[i]] <= wrData[i];
            if (memWrite[i]) ram[i][aluF[i][5:0]] <= rdB[i];
        end
    end

    // Reference semantics keyed on the instruction's funct field.
    function automatic logic isRFunct(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
    endfunction

    function automatic logic [31:0] refResult(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h2B:   return (a < b) ? 32'd1 : 32'd0;
            default: return b << a[4:0];
        endcase
    endfunction

    function automatic logic [2:0] refAluOp(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b100;
            6'h22:   return 3'b101;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h26:   return 3'b010;
            6'h27:   return 3'b011;
            6'h2B:   return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic refOverflow(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = (fn == 6'h20) ? sa + sb : sa - sb;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic preloadWord(input logic isRam, input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        plEn = 1'b1; plRam = isRam; plIdx = idx; plData = data;
        @(posedge clk);
        #1 plEn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (isRam) expRam[i][idx] = data;
            else       expRegs[i][idx[4:0]] = data;
        end
    endtask

    task automatic checkResetValues(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s_wr[%0d]", tag, i), 32'(writeReg[i]), 32'd0);
            checkOutput($sformatf("%s_mw[%0d]", tag, i), 32'(memWrite[i]), 32'd0);
            checkOutput($sformatf("%s_alu[%0d]", tag, i), 32'(aluOp[i]), 32'd4);
            checkOutput($sformatf("%s_wds[%0d]", tag, i), 32'(wrDataS[i]), 32'd0);
            checkOutput($sformatf("%s_regs[%0d]", tag, i), {17'd0, rsOut[i], rtOut[i], rdOut[i]}, 32'd0);
            checkOutput($sformatf("%s_flags[%0d]", tag, i),
                        {27'd0, busy[i], done[i], illegal[i], ovfTrap[i], zfQ[i]}, 32'd0);
        end
    endtask

    // Runs one instruction through both copies; instr_valid stays high with junk while busy.
    task automatic applyStimulus(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  s, t, d;
        logic        isR, isLoad, isStore, legal;
        logic [31:0] aV [2];
        logic [31:0] bV [2];
        logic [31:0] res [2];
        logic [31:0] sum;
        logic [5:0]  addrV [2];
        logic        trap [2];
        int          expDone [2];
        logic [15:0] expWr [2];
        logic [15:0] expMw [2];
        logic [15:0] expWds [2];
        logic [15:0] expBusy [2];
        logic [15:0] obsWr [2];
        logic [15:0] obsMw [2];
        logic [15:0] obsWds [2];
        logic [15:0] obsBusy [2];
        int          obsDone [2];
        logic        obsIll [2];
        logic        obsTrap [2];
        logic        obsRdy [2];
        logic        obsZf [2];
        logic [2:0]  obsAlu [2];
        logic [14:0] obsFields [2];

        op = ins[31:26]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11]; fn = ins[5:0];
        isR     = (op == 6'h00) && isRFunct(fn);
        isLoad  = (op == 6'h23);
        isStore = (op == 6'h2B);
        legal   = isR || isLoad || isStore;

        for (int i = 0; i < 2; i++) begin
            aV[i]    = expRegs[i][s];
            bV[i]    = expRegs[i][t];
            sum      = aV[i] + bV[i];
            addrV[i] = sum[5:0];
            trap[i]  = (i == 0) && isR && (fn == 6'h20 || fn == 6'h22) && refOverflow(fn, aV[i], bV[i]);
            res[i]   = isR ? refResult(fn, aV[i], bV[i]) : sum;
            if (!legal)       expDone[i] = 2;
            else if (trap[i]) expDone[i] = 3;
            else if (isLoad)  expDone[i] = 5;
            else              expDone[i] = 4;
            expWr[i]   = (isR && !trap[i]) ? 16'h0008 : (isLoad ? 16'h0010 : 16'h0000);
            expMw[i]   = isStore ? 16'h0008 : 16'h0000;
            expWds[i]  = isLoad ? 16'h0018 : 16'h0000;
            expBusy[i] = (16'd1 << expDone[i]) - 16'd2;
            obsWr[i] = '0; obsMw[i] = '0; obsWds[i] = '0; obsBusy[i] = '0;
            obsDone[i] = 0; obsIll[i] = 1'b0; obsTrap[i] = 1'b0; obsRdy[i] = 1'b0; obsZf[i] = 1'b0;
            obsAlu[i] = '0; obsFields[i] = '0;
        end

        @(negedge clk);
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("ready_before[%0d]", i), 32'(instrReady[i]), 32'd1);
        instr = ins;
        instrValid = 2'b11;
        @(posedge clk);
        #1 instr = 32'hFC00_0000 | ($urandom() & 32'h03FF_FFFF);

        for (int k = 1; k <= 12 && !(obsDone[0] != 0 && obsDone[1] != 0); k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (obsDone[i] == 0) begin
                    obsWr[i][k]   = writeReg[i];
                    obsMw[i][k]   = memWrite[i];
                    obsWds[i][k]  = (wrDataS[i] == 2'b01);
                    obsBusy[i][k] = busy[i];
                    if (k == 1) begin
                        obsAlu[i]    = aluOp[i];
                        obsFields[i] = {rsOut[i], rtOut[i], rdOut[i]};
                    end
                    if (done[i]) begin
                        obsDone[i] = k;
                        obsIll[i]  = illegal[i];
                        obsTrap[i] = ovfTrap[i];
                        obsRdy[i]  = instrReady[i];
                        obsZf[i]   = zfQ[i];
                        instrValid[i] = 1'b0;
                    end
                end
            end
        end
        instrValid = 2'b00;

        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("done_cycle[%0d] ins=%h", i, ins), 32'(obsDone[i]), 32'(expDone[i]));
            checkOutput($sformatf("illegal[%0d]", i), 32'(obsIll[i]), 32'(!legal));
            checkOutput($sformatf("ovf_trap[%0d]", i), 32'(obsTrap[i]), 32'(trap[i]));
            checkOutput($sformatf("ready_at_done[%0d]", i), 32'(obsRdy[i]), 32'd1);
            checkOutput($sformatf("write_reg_cycles[%0d]", i), 32'(obsWr[i]), 32'(expWr[i]));
            checkOutput($sformatf("mem_write_cycles[%0d]", i), 32'(obsMw[i]), 32'(expMw[i]));
            checkOutput($sformatf("wr_data_s_cycles[%0d]", i), 32'(obsWds[i]), 32'(expWds[i]));
            checkOutput($sformatf("busy_cycles[%0d]", i), 32'(obsBusy[i]), 32'(expBusy[i]));
            if (legal) begin
                checkOutput($sformatf("alu_op[%0d]", i), 32'(obsAlu[i]), isR ? 32'(refAluOp(fn)) : 32'd4);
                checkOutput($sformatf("rs_rt_rd[%0d]", i), 32'(obsFields[i]), 32'({s, t, d}));
                expZf[i] = (res[i] == 32'd0);
            end
            checkOutput($sformatf("zf_q[%0d]", i), 32'(obsZf[i]), 32'(expZf[i]));
            if (isR && !trap[i]) expRegs[i][d] = res[i];
            if (isLoad)          expRegs[i][d] = expRam[i][addrV[i]];
            if (isStore)         expRam[i][addrV[i]] = bV[i];
            checkOutput($sformatf("reg_rd[%0d]", i), regs[i][d], expRegs[i][d]);
            if (isStore)
                checkOutput($sformatf("ram_word[%0d]", i), ram[i][addrV[i]], expRam[i][addrV[i]]);
        end
    endtask

    // Aborts an R-type in WB and checks nothing is committed or reported.
    task automatic resetDuringWb(input logic [31:0] ins);
        logic [4:0] d;
        d = ins[15:11];
        @(negedge clk);
        instr = ins;
        instrValid = 2'b11;
        @(posedge clk);
        #1 instrValid = 2'b00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("wb_before_reset[%0d]", i), 32'(writeReg[i]), 32'd1);
        reset = 1'b1;
        #1 checkResetValues("mid_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) expZf[i] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                checkOutput($sformatf("no_done_after_abort[%0d]", i), 32'(done[i]), 32'd0);
        end
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("rd_after_abort[%0d]", i), regs[i][d], expRegs[i][d]);
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  op, fn;
        int          sel;
        logic [5:0]  fnTab [8];

        fnTab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
        reset = 1'b1; instr = 32'd0; instrValid = 2'b00;
        plEn = 1'b0; plRam = 1'b0; plIdx = '0; plData = '0;
        expZf = '{1'b0, 1'b0};
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("ready_after_reset[%0d]", i), 32'(instrReady[i]), 32'd1);

        for (int r = 0; r < 32; r++) preloadWord(1'b0, 6'(r), $urandom());
        for (int m = 0; m < 64; m++) preloadWord(1'b1, 6'(m), $urandom());

        preloadWord(1'b0, 6'd0, 32'h0000_FFFF);
        preloadWord(1'b0, 6'd1, 32'hFFFF_0000);
        preloadWord(1'b1, 6'h3F, 32'hAAAA_AAAA);
        applyStimulus({6'h00, 5'd0, 5'd1, 5'd2, 5'd0, 6'h20});
        checkOutput("add_reg2", regs[0][2], 32'hFFFF_FFFF);
        applyStimulus({6'h23, 5'd0, 5'd1, 5'd3, 11'd0});
        checkOutput("load_reg3", regs[0][3], 32'hAAAA_AAAA);
        applyStimulus({6'h2B, 5'd2, 5'd3, 5'd0, 11'd0});
        checkOutput("store_ram29", ram[0][6'h29], 32'hAAAA_AAAA);

        preloadWord(1'b0, 6'd4, 32'h7FFF_FFFF);
        preloadWord(1'b0, 6'd5, 32'h0000_0001);
        preloadWord(1'b0, 6'd6, 32'h1234_5678);
        applyStimulus({6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20});
        checkOutput("trap_rd_kept", regs[0][6], 32'h1234_5678);
        checkOutput("notrap_rd_written", regs[1][6], 32'h8000_0000);

        applyStimulus({6'h3F, 5'd1, 5'd2, 5'd3, 11'h155});

        preloadWord(1'b0, 6'd7, 32'hDEAD_BEEF);
        resetDuringWb({6'h00, 5'd0, 5'd1, 5'd7, 5'd0, 6'h25});

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom_range(0, 63));
            if (sel <= 5) begin
                op = 6'h00;
                fn = fnTab[$urandom_range(0, 7)];
            end else if (sel == 6) begin
                op = 6'h23;
            end else if (sel == 7) begin
                op = 6'h2B;
            end else if (sel == 8) begin
                op = 6'($urandom_range(1, 63));
                while (op == 6'h23 || op == 6'h2B) op = 6'($urandom_range(1, 63));
            end else begin
                op = 6'h00;
                while (isRFunct(fn)) fn = 6'($urandom_range(0, 63));
            end
            ins = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn};
            applyStimulus(ins);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control unit for the register-file / ALU / 64x32 RAM datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. It then steps the datapath by driving Write_Reg, Mem_Write, ALU_OP, wr_data_s, rs, rt and rd cycle by cycle, replacing hand-driven control. Datapath flags ZF and OF return to the sequencer for flag capture and overflow trapping.

## Interface
- TRAP_ON_OF, default 1: when 1, an add or sub with OF=1 suppresses write-back.
- clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- instr  in  32  instruction: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  high only in IDLE.
- ZF  in  1  datapath zero flag.
- OF  in  1  datapath overflow flag.
- Write_Reg  out  1  register-file write enable.
- Mem_Write  out  1  RAM write enable; the datapath writes R_Data_B to RAM[F].
- ALU_OP  out  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLTU, 111 SLLV.
- wr_data_s  out  2  write-data select: 00 selects F, 01 selects M_R_Data; 10 and 11 are never driven.
- rs, rt, rd  out  5 each  register addresses.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse on completion.
- illegal  out  1  one-cycle pulse, coincident with done, for an undecodable instruction.
- ovf_trap  out  1  one-cycle pulse, coincident with done, when the overflow trap fires.
- zf_q  out  1  ZF latched at the end of EXEC.

## Operation
- Reset values:
  - state IDLE and IR = 0.
  - Write_Reg = 0, Mem_Write = 0, wr_data_s = 00, ALU_OP = 100.
  - rs = rt = rd = 0.
  - busy = 0, done = 0, illegal = 0, ovf_trap = 0, zf_q = 0.
  - instr_ready = 1 once Reset is low.
- Accept: on an edge with instr_valid & instr_ready, latch instr into IR and go to DECODE. instr_valid is ignored while busy.
- Decode rules:
  - op = 000000 is R-type. funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101011 SLTU, 000100 SLLV.
  - op = 100011 is LOAD: REG[rd] <= RAM[REG[rs]+REG[rt]].
  - op = 101011 is STORE: RAM[REG[rs]+REG[rt]] <= REG[rt].
  - Any other op or funct is illegal.
  - LOAD and STORE force ALU_OP = 100.
- Output assignment:
  - rs, rt, rd and ALU_OP are registered from IR and held stable from DECODE through the final state.
  - Write_Reg is high only in WB.
  - Mem_Write is high only in MEM of a STORE.
  - wr_data_s = 01 only in MEM and WB of a LOAD; 00 otherwise.
- States and transitions:
  - IDLE -> DECODE on accept.
  - DECODE -> EXEC if the instruction is legal. If illegal, DECODE -> IDLE with done and illegal pulsed and no strobes asserted.
  - EXEC: zf_q <= ZF at the end of the cycle. Then R-type -> WB; LOAD and STORE -> MEM.
  - R-type overflow: if TRAP_ON_OF = 1, the op is ADD or SUB, and OF = 1 at the end of EXEC, go EXEC -> IDLE with done and ovf_trap pulsed. No register write occurs.
  - MEM: for LOAD, the RAM read edge occurs and the state goes -> WB. For STORE, the RAM write commits on the closing edge and the state goes -> IDLE.
  - WB: the register write commits on the closing edge; then -> IDLE.
- done and its companion pulses are registered; they are high for the first IDLE cycle after the last state.
- When Reset asserts mid-instruction, the sequencer aborts immediately:
  - Write_Reg and Mem_Write drop combinationally with Reset, so no partial commit occurs.
  - No done pulse is produced.

## Timing
- Cycle 0 is the accept edge.
- R-type: DECODE c1, EXEC c2, WB c3; done in c4, when instr_ready is high again. Back-to-back accept is possible at the end of c4.
- LOAD: DECODE c1, EXEC c2, MEM c3, WB c4; done in c5.
- STORE: DECODE c1, EXEC c2, MEM c3; done in c4.
- Illegal: done and illegal in c2. Overflow trap: done and ovf_trap in c3.
- Strobes are Moore outputs of state; they do not glitch within a cycle.

## Test plan
- Reset, then ADD with rs=0, rt=1, rd=2, where REG0=0000_FFFF and REG1=FFFF_0000. Required: ALU_OP=100 from c1, Write_Reg=1 only in c3, wr_data_s=00, REG2=FFFF_FFFF, done in c4, zf_q=0.
- LOAD with rs=0, rt=1, rd=3, where RAM[3F]=AAAA_AAAA. Required: Mem_Write=0 throughout, wr_data_s=01 in c3-c4, Write_Reg only in c4, REG3=AAAA_AAAA, done in c5.
- STORE with rs=2, rt=3, where REG2=FFFF_FFFF and REG3=AAAA_AAAA. Required: address = AAAA_AAA9, so RAM word 6'b101001; Mem_Write=1 only in c3; RAM[29h]=AAAA_AAAA; Write_Reg never asserts; done in c4.
- ADD with 7FFF_FFFF + 1 (OF=1), TRAP_ON_OF=1. Required: Write_Reg never asserts, rd is unchanged, done and ovf_trap both high in c3. Repeat with TRAP_ON_OF=0: the write-back occurs and done comes in c4.
- op=111111. Required: illegal and done in c2, no strobes. Also hold instr_valid high while busy: only the first instruction is accepted.
- Assert Reset during WB of an R-type. Required: Write_Reg falls the same instant, all outputs take their reset values, rd is unchanged, and no done pulse occurs.
